// File: rtl/s32x_vdp_bus_initiator_pkg.sv
// rtl/s32x_vdp_bus_initiator_pkg.sv - shared 32X bridge types, FSM encodings and request legality check
package s32x_vdp_bus_initiator_pkg;

  typedef enum logic [1:0] {
    SEL_REG  = 2'b00,
    SEL_PAL  = 2'b01,
    SEL_DRAM = 2'b10
  } vdp_sel_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_LONG = 2'b10
  } acc_size_t;

  typedef enum logic [2:0] {
    INIT_IDLE    = 3'd0,
    INIT_SETUP   = 3'd1,
    INIT_STROBE  = 3'd2,
    INIT_RELEASE = 3'd3,
    INIT_FIN     = 3'd4
  } init_state_t;

  // Plain constants so the FSM register stays a bare logic vector
  localparam logic [2:0] ST_IDLE    = INIT_IDLE;
  localparam logic [2:0] ST_SETUP   = INIT_SETUP;
  localparam logic [2:0] ST_STROBE  = INIT_STROBE;
  localparam logic [2:0] ST_RELEASE = INIT_RELEASE;
  localparam logic [2:0] ST_FIN     = INIT_FIN;

  localparam int TOUT_W = 16;

  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] sel,
                                       input logic [1:0] addr_lo);
    return (sel == 2'b11) || (size == 2'b11) ||
           ((size != SZ_BYTE) && addr_lo[0]) ||
           ((size == SZ_LONG) && addr_lo[1]);
  endfunction

endpackage

// File: rtl/s32x_bus_timeout.sv
// rtl/s32x_bus_timeout.sv - loadable down-counter; expired marks the last permitted cycle
module s32x_bus_timeout #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  // A load value of 0 parks the counter at 0, which never expires
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = en && (count == W'(1));

endmodule

// File: rtl/s32x_vdp_bus_initiator.sv
// rtl/s32x_vdp_bus_initiator.sv - 32X VDP bus initiator: host request to CS/strobe/ACK_N handshake
module s32x_vdp_bus_initiator
  import s32x_vdp_bus_initiator_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int SETUP_CYC = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic [1:0]  SEL,
  input  logic [17:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [16:0] A,
  output logic [15:0] DO,
  input  logic [15:0] DI,
  output logic        RD_N,
  output logic        LWR_N,
  output logic        UWR_N,
  output logic        REG_CS_N,
  output logic        PAL_CS_N,
  output logic        DRAM_CS_N,
  input  logic        ACK_N
);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic [1:0]  lat_sel;
  logic [17:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        half;
  logic        err_flag;
  logic [7:0]  setup_cnt;
  logic [31:0] rdata_q;
  logic [31:0] rd_capture;
  logic        tmr_expired;
  logic        cs_active;
  logic        strobe_on;
  logic        byte_odd;
  logic        byte_even;

  s32x_bus_timeout #(
    .W(TOUT_W)
  ) u_timeout (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (state_nx != state),
    .load_val(TOUT_W'(TIMEOUT)),
    .en      (BUSY),
    .expired (tmr_expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (REQ) state_nx = req_illegal(SIZE, SEL, ADDR[1:0]) ? ST_FIN : ST_SETUP;
      end
      ST_SETUP: begin
        // A stale ACK_N holds us here; only then may the timer abort the access
        if (!ACK_N && tmr_expired) state_nx = ST_FIN;
        else if (ACK_N && (setup_cnt == 8'd0)) state_nx = ST_STROBE;
      end
      ST_STROBE: begin
        if (!ACK_N) state_nx = ST_RELEASE;
        else if (tmr_expired) state_nx = ST_FIN;
      end
      ST_RELEASE: begin
        if (ACK_N) state_nx = ((lat_size == SZ_LONG) && !half) ? ST_SETUP : ST_FIN;
        else if (tmr_expired) state_nx = ST_FIN;
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Big-endian lanes: even byte on [15:8]; long halves fill [31:16] first
  always_comb begin
    rd_capture = rdata_q;
    if (lat_size == SZ_BYTE) rd_capture = {24'h0, lat_addr[0] ? DI[7:0] : DI[15:8]};
    else if ((lat_size == SZ_LONG) && !half) rd_capture[31:16] = DI;
    else if (lat_size == SZ_LONG) rd_capture[15:0] = DI;
    else rd_capture = {16'h0, DI};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_sel   <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
      half      <= 1'b0;
      err_flag  <= 1'b0;
      setup_cnt <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            lat_we    <= WE;
            lat_size  <= SIZE;
            lat_sel   <= SEL;
            lat_addr  <= ADDR;
            lat_wdata <= WDATA;
            half      <= 1'b0;
            err_flag  <= req_illegal(SIZE, SEL, ADDR[1:0]);
            rdata_q   <= '0;
          end
        end
        ST_SETUP: begin
          if (setup_cnt != 8'd0) setup_cnt <= setup_cnt - 8'd1;
          if (!ACK_N && tmr_expired) err_flag <= 1'b1;
        end
        ST_STROBE: begin
          if (!ACK_N) begin
            if (!lat_we) rdata_q <= rd_capture;
          end else if (tmr_expired) begin
            err_flag <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (ACK_N) begin
            if (lat_size == SZ_LONG) half <= 1'b1;
          end else if (tmr_expired) begin
            err_flag <= 1'b1;
          end
        end
        default: ;
      endcase
      if ((state_nx == ST_SETUP) && (state != ST_SETUP)) setup_cnt <= 8'(SETUP_CYC - 1);
    end
  end

  assign cs_active = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_RELEASE);
  assign strobe_on = (state == ST_STROBE);
  assign byte_odd  = (lat_size == SZ_BYTE) && lat_addr[0];
  assign byte_even = (lat_size == SZ_BYTE) && !lat_addr[0];

  assign BUSY  = cs_active;
  assign DONE  = (state == ST_FIN) && !err_flag;
  assign ERR   = (state == ST_FIN) && err_flag;
  assign RDATA = rdata_q;

  // Address and data derive only from request latches, so they cannot move mid-strobe
  assign A  = lat_addr[17:1] + {16'h0, half};
  assign DO = (lat_size == SZ_BYTE) ? {2{lat_wdata[7:0]}} :
              ((lat_size == SZ_LONG) && !half) ? lat_wdata[31:16] : lat_wdata[15:0];

  assign RD_N  = !(strobe_on && !lat_we);
  assign UWR_N = !(strobe_on && lat_we && !byte_odd);
  assign LWR_N = !(strobe_on && lat_we && !byte_even);

  assign REG_CS_N  = !(cs_active && (lat_sel == SEL_REG));
  assign PAL_CS_N  = !(cs_active && (lat_sel == SEL_PAL));
  assign DRAM_CS_N = !(cs_active && (lat_sel == SEL_DRAM));

endmodule

// File: tb/tb_s32x_vdp_bus_initiator.sv
// tb/tb_s32x_vdp_bus_initiator.sv - randomized bench with VDP responder model and request-level reference
module tb_s32x_vdp_bus_initiator;

  localparam int TOUT  = 16;
  localparam int SETUP = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ;
  logic        WE;
  logic [1:0]  SIZE;
  logic [1:0]  SEL;
  logic [17:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [16:0] A;
  logic [15:0] DO;
  logic [15:0] DI;
  logic        RD_N;
  logic        LWR_N;
  logic        UWR_N;
  logic        REG_CS_N;
  logic        PAL_CS_N;
  logic        DRAM_CS_N;
  logic        ACK_N;

  s32x_vdp_bus_initiator #(
    .TIMEOUT  (TOUT),
    .SETUP_CYC(SETUP)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .WE       (WE),
    .SIZE     (SIZE),
    .SEL      (SEL),
    .ADDR     (ADDR),
    .WDATA    (WDATA),
    .RDATA    (RDATA),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .A        (A),
    .DO       (DO),
    .DI       (DI),
    .RD_N     (RD_N),
    .LWR_N    (LWR_N),
    .UWR_N    (UWR_N),
    .REG_CS_N (REG_CS_N),
    .PAL_CS_N (PAL_CS_N),
    .DRAM_CS_N(DRAM_CS_N),
    .ACK_N    (ACK_N)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]  cs_n;
    logic [16:0] a;
    logic [15:0] d;
    logic        rd_n;
    logic        uwr_n;
    logic        lwr_n;
  } bus_t;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] di_of(input logic [2:0] cs_n, input logic [16:0] a);
    return 16'(a * 17'd40503) ^ {13'h0, cs_n} ^ 16'hA5C3;
  endfunction

  // Responder: records each strobed cycle, checks setup length and signal stability
  int   ack_dly   = 0;
  int   rel_dly   = 0;
  bit   ack_never = 0;
  bus_t obs [0:1023];
  int   len_arr [0:1023];
  int   obs_n = 0;
  int   stab_viol = 0;
  int   setup_viol = 0;
  int   cs_cnt = 0;
  int   s_len = 0;
  int   r_len = 0;
  int   pre_cnt = 0;
  bit   in_strobe = 0;
  logic [35:0] cur_sig;
  logic [35:0] last_sig = '0;
  logic [35:0] held_sig = '0;
  bus_t rec;

  always @(negedge CLK) begin
    cur_sig = {DRAM_CS_N, PAL_CS_N, REG_CS_N, A, DO};
    if (!(REG_CS_N && PAL_CS_N && DRAM_CS_N)) cs_cnt++;
    if (!(RD_N && LWR_N && UWR_N)) begin
      if (!in_strobe) begin
        in_strobe = 1;
        s_len = 0;
        held_sig = cur_sig;
        rec.cs_n = {DRAM_CS_N, PAL_CS_N, REG_CS_N};
        rec.a = A;
        rec.d = RD_N ? DO : 16'h0;
        rec.rd_n = RD_N;
        rec.uwr_n = UWR_N;
        rec.lwr_n = LWR_N;
        if (obs_n < 1024) obs[obs_n] = rec;
        obs_n++;
        if (pre_cnt < SETUP) setup_viol++;
      end else if (cur_sig != held_sig) begin
        stab_viol++;
      end
      s_len++;
      if (obs_n <= 1024) len_arr[obs_n-1] = s_len;
      DI = di_of({DRAM_CS_N, PAL_CS_N, REG_CS_N}, A);
      if (!ack_never && (s_len > ack_dly)) ACK_N = 1'b0;
      pre_cnt = 0;
    end else begin
      if (in_strobe) begin
        in_strobe = 0;
        r_len = 0;
      end
      if (!ACK_N) begin
        r_len++;
        if (r_len > rel_dly) ACK_N = 1'b1;
      end
      if (!(REG_CS_N && PAL_CS_N && DRAM_CS_N))
        pre_cnt = (cur_sig == last_sig) ? pre_cnt + 1 : 1;
      else
        pre_cnt = 0;
    end
    last_sig = cur_sig;
  end

  // Reference: the list of bus cycles and read data a request should produce
  bus_t        exp_q[$];
  logic [31:0] exp_rd;
  bit          exp_ill;

  task automatic model(input logic we, input logic [1:0] size, input logic [1:0] sel,
                       input logic [17:0] addr, input logic [31:0] wdata);
    bus_t e;
    logic [15:0] di;
    int nhalf;
    exp_q.delete();
    exp_rd = 32'h0;
    exp_ill = (sel == 2'd3) || (size == 2'd3) || ((size != 2'd0) && addr[0]) ||
              ((size == 2'd2) && addr[1]);
    if (!exp_ill) begin
      nhalf = (size == 2'd2) ? 2 : 1;
      for (int h = 0; h < nhalf; h++) begin
        e.cs_n = ~(3'b001 << sel);
        e.a = addr[17:1] + 17'(h);
        e.rd_n = we;
        di = di_of(e.cs_n, e.a);
        if (size == 2'd0) begin
          e.uwr_n = !we || addr[0];
          e.lwr_n = !we || !addr[0];
          e.d = we ? {wdata[7:0], wdata[7:0]} : 16'h0;
          if (!we) exp_rd = {24'h0, addr[0] ? di[7:0] : di[15:8]};
        end else begin
          e.uwr_n = !we;
          e.lwr_n = !we;
          e.d = !we ? 16'h0 : ((size == 2'd2) && (h == 0)) ? wdata[31:16] : wdata[15:0];
          if (!we) begin
            if (size == 2'd1) exp_rd = {16'h0, di};
            else if (h == 0) exp_rd[31:16] = di;
            else exp_rd[15:0] = di;
          end
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic [1:0] sel,
                        input logic [17:0] addr, input logic [31:0] wdata,
                        input int adly, input int rdly, input bit never);
    int base, sv_base, su_base, cs_base, nd, ne, lat, busy_seen, exp_n, got_n;
    logic [31:0] rd_seen;
    model(we, size, sel, addr, wdata);
    ack_dly = adly;
    rel_dly = rdly;
    ack_never = never;
    base = obs_n;
    sv_base = stab_viol;
    su_base = setup_viol;
    cs_base = cs_cnt;
    @(negedge CLK);
    WE = we; SIZE = size; SEL = sel; ADDR = addr; WDATA = wdata; REQ = 1'b1;
    nd = 0; ne = 0; lat = 0; busy_seen = 0; rd_seen = 32'h0;
    for (int c = 0; (c < 200) && (nd + ne == 0); c++) begin
      @(negedge CLK);
      lat++;
      busy_seen += int'(BUSY);
      if (DONE) begin nd++; rd_seen = RDATA; end
      if (ERR) ne++;
    end
    check("finished_in_bound", nd + ne, 1);
    REQ = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE) nd++;
      if (ERR) ne++;
    end
    check("done_pulses", nd, (exp_ill || never) ? 0 : 1);
    check("err_pulses", ne, (exp_ill || never) ? 1 : 0);
    check("busy_seen", busy_seen > 0, !exp_ill);
    exp_n = never ? 1 : exp_q.size();
    got_n = obs_n - base;
    check("bus_cycles", got_n, exp_n);
    for (int i = 0; i < exp_n && i < got_n; i++) check("bus_cycle", obs[base+i], exp_q[i]);
    if (exp_ill) begin
      check("ill_latency", lat, 1);
      check("ill_cs_activity", cs_cnt - cs_base, 0);
    end
    if (!we && !exp_ill && !never) check("rdata", rd_seen, exp_rd);
    if (never && got_n > 0) check("timeout_strobe_len", len_arr[base], TOUT);
    check("stable_while_strobed", stab_viol - sv_base, 0);
    check("setup_cycles", setup_viol - su_base, 0);
    check("idle_outputs", {BUSY, RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 7'h3F);
  endtask

  initial begin
    bit seen;
    logic [1:0]  sz, sl;
    logic [17:0] ad;
    RST_N = 1'b0; REQ = 1'b0; WE = 1'b0; SIZE = 2'b00; SEL = 2'b00;
    ADDR = '0; WDATA = '0; DI = '0; ACK_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_strobes_cs", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 6'h3F);
    check("reset_flags", {BUSY, DONE, ERR}, 3'b000);
    check("reset_a_do", {A, DO}, 33'h0);
    check("reset_rdata", RDATA, 32'h0);
    RST_N = 1'b1;

    do_req(1'b1, 2'b01, 2'b00, 18'h0000A, 32'h0000_0001, 1, 1, 0);
    do_req(1'b0, 2'b00, 2'b01, 18'h00013, 32'h0, 2, 0, 0);
    do_req(1'b1, 2'b10, 2'b10, 18'h00100, 32'h1234_5678, 0, 2, 0);
    do_req(1'b1, 2'b01, 2'b00, 18'h00020, 32'h0000_BEEF, 0, 0, 1);
    do_req(1'b0, 2'b01, 2'b00, 18'h00003, 32'h0, 0, 0, 0);
    do_req(1'b1, 2'b01, 2'b11, 18'h00010, 32'h0000_5555, 0, 0, 0);
    do_req(1'b0, 2'b10, 2'b10, 18'h00202, 32'h0, 1, 1, 0);
    do_req(1'b0, 2'b10, 2'b00, 18'h00404, 32'h0, 3, 1, 0);

    // Reset during the first strobe of a long read
    ack_dly = 10; rel_dly = 0; ack_never = 0;
    @(negedge CLK);
    WE = 1'b0; SIZE = 2'b10; SEL = 2'b10; ADDR = 18'h00040; REQ = 1'b1;
    seen = 0;
    for (int i = 0; (i < 20) && !seen; i++) begin
      @(negedge CLK);
      seen = !RD_N;
    end
    check("rst_reached_strobe", seen, 1'b1);
    #2 RST_N = 1'b0;
    REQ = 1'b0;
    #1;
    check("rst_async_release", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 6'h3F);
    check("rst_async_busy", BUSY, 1'b0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    do_req(1'b0, 2'b10, 2'b10, 18'h00040, 32'h0, 2, 1, 0);

    for (int n = 0; n < 60; n++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sl = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = 18'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) ad[1:0] = 2'b00;
        else if (sz == 2'b01) ad[0] = 1'b0;
      end
      do_req(1'($urandom), sz, sl, ad, $urandom, $urandom_range(0, 5), $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
